// File: rtl/if_id_queue_if.sv
// Handshake bundle between the fetch/decode front end, instruction memory and the EX stage.
// master = front end, slave = memory/EX side.
interface if_id_queue_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [2:0]  id_funct3;
    logic        id_subtype;
    logic        id_imm_sel;
    logic        id_alu;
    logic        id_lui;
    logic        id_jal;
    logic        id_jalr;
    logic        id_branch;
    logic        id_mem_write;
    logic        id_mem_to_reg;
    logic        id_illegal;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output id_valid, id_pc, id_instr, id_imm, id_rs1, id_rs2, id_rd, id_funct3,
        output id_subtype, id_imm_sel, id_alu, id_lui, id_jal, id_jalr, id_branch,
        output id_mem_write, id_mem_to_reg, id_illegal,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  id_valid, id_pc, id_instr, id_imm, id_rs1, id_rs2, id_rd, id_funct3,
        input  id_subtype, id_imm_sel, id_alu, id_lui, id_jal, id_jalr, id_branch,
        input  id_mem_write, id_mem_to_reg, id_illegal,
        output id_ready
    );
endinterface

// File: rtl/if_id_queue.sv
// RISC-V fetch/decode front end: credit-limited fetch, DEPTH-entry instruction FIFO with PC tags,
// registered decode stage with valid/ready handshake, redirect with in-flight discard, sticky fault flag.
module if_id_queue #(
    parameter logic [31:0] RESET = 32'h0000_0000,
    parameter int          DEPTH = 4,
    localparam int         PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [31:0]       flush_pc,
    if_id_queue_if.master     bus,
    output logic [PTR_W:0]    fifo_count,
    output logic              exception
);
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_ARITHI = 7'b0010011;
    localparam logic [6:0] OP_ARITHR = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SR     = 3'b101;
    localparam logic [PTR_W+1:0] DEPTH_U = DEPTH[PTR_W+1:0];

    typedef struct packed {
        logic [31:0] imm;
        logic        imm_sel;
        logic        alu;
        logic        lui;
        logic        jal;
        logic        jalr;
        logic        branch;
        logic        mem_write;
        logic        mem_to_reg;
        logic        illegal;
        logic        subtype;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t       d;
        logic [6:0] op;
        logic [2:0] f3;
        op = ins[6:0];
        f3 = ins[14:12];
        d  = '0;
        case (op)
            OP_LOAD: begin
                d.imm        = {{20{ins[31]}}, ins[31:20]};
                d.imm_sel    = 1'b1;
                d.mem_to_reg = 1'b1;
            end
            OP_STORE: begin
                d.imm       = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                d.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                d.imm    = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                d.branch = 1'b1;
            end
            OP_JALR: begin
                d.imm     = {{20{ins[31]}}, ins[31:20]};
                d.imm_sel = 1'b1;
                d.jalr    = 1'b1;
            end
            OP_JAL: begin
                d.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                d.jal = 1'b1;
            end
            OP_ARITHI: begin
                // Shift-immediates carry a 5-bit shamt; funct7 must not leak into the operand.
                if (f3 == F3_SLL || f3 == F3_SR) d.imm = {27'b0, ins[24:20]};
                else                             d.imm = {{20{ins[31]}}, ins[31:20]};
                d.imm_sel = 1'b1;
                d.alu     = 1'b1;
            end
            OP_ARITHR: begin
                d.alu = 1'b1;
            end
            OP_LUI: begin
                d.imm = {ins[31:12], 12'b0};
                d.lui = 1'b1;
            end
            default: begin
                d.illegal = 1'b1;
            end
        endcase
        d.subtype = ins[30] && !(op == OP_ARITHI && f3 == F3_ADD);
        return d;
    endfunction

    logic [31:0] pc;
    cnt_t        outstanding;
    cnt_t        drop;
    ptr_t        tag_wr;
    ptr_t        tag_rd;
    logic [31:0] tag_q [DEPTH];

    ptr_t        wr_ptr;
    ptr_t        rd_ptr;
    cnt_t        count;
    logic [31:0] fifo_data [DEPTH];
    logic [31:0] fifo_pc   [DEPTH];

    logic        vld_p1;
    logic [31:0] pc_p1;
    logic [31:0] instr_p1;
    dec_t        dec_p1;

    logic [PTR_W+1:0] in_use;
    logic             credit_ok;
    logic             req_fire;
    logic             rsp_fire;
    logic             push;
    logic             load_id;

    // Outstanding requests plus buffered words never exceed DEPTH, so every response has a slot.
    assign in_use    = {1'b0, outstanding} + {1'b0, count};
    assign credit_ok = in_use < DEPTH_U;

    assign bus.imem_req_valid = reset && !exception && !flush && credit_ok;
    assign bus.imem_req_addr  = pc;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_fire = bus.imem_rsp_valid && (outstanding != '0);
    assign push     = rsp_fire && (drop == '0) && !flush;
    assign load_id  = (count != '0) && (!vld_p1 || bus.id_ready) && !flush;

    // ---- fetch stage: PC, credit and tag queue ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET;
            outstanding <= '0;
            drop        <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
        end else begin
            if (flush)         pc <= flush_pc;
            else if (req_fire) pc <= pc + 32'd4;

            outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(rsp_fire);

            if (flush)                         drop <= outstanding - cnt_t'(rsp_fire);
            else if (rsp_fire && drop != '0)   drop <= drop - cnt_t'(1);

            if (req_fire) tag_wr <= tag_wr + ptr_t'(1);
            if (rsp_fire) tag_rd <= tag_rd + ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) tag_q[tag_wr] <= pc;
    end

    // ---- response stage p0: instruction FIFO ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + ptr_t'(1);
            if (load_id) rd_ptr <= rd_ptr + ptr_t'(1);
            count <= count + cnt_t'(push) - cnt_t'(load_id);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.imem_rsp_data;
            fifo_pc[wr_ptr]   <= tag_q[tag_rd];
        end
    end

    // ---- decode stage p1: registered ID->EX bundle ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            pc_p1    <= '0;
            instr_p1 <= '0;
            dec_p1   <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (load_id) begin
            vld_p1   <= 1'b1;
            pc_p1    <= fifo_pc[rd_ptr];
            instr_p1 <= fifo_data[rd_ptr];
            dec_p1   <= decode(fifo_data[rd_ptr]);
        end else if (bus.id_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exception <= 1'b0;
        end else if ((flush && flush_pc[1:0] != 2'b00) || (vld_p1 && dec_p1.illegal)) begin
            exception <= 1'b1;
        end
    end

    assign fifo_count        = count;
    assign bus.id_valid      = vld_p1;
    assign bus.id_pc         = pc_p1;
    assign bus.id_instr      = instr_p1;
    assign bus.id_imm        = dec_p1.imm;
    assign bus.id_rs1        = instr_p1[19:15];
    assign bus.id_rs2        = instr_p1[24:20];
    assign bus.id_rd         = instr_p1[11:7];
    assign bus.id_funct3     = instr_p1[14:12];
    assign bus.id_subtype    = dec_p1.subtype;
    assign bus.id_imm_sel    = dec_p1.imm_sel;
    assign bus.id_alu        = dec_p1.alu;
    assign bus.id_lui        = dec_p1.lui;
    assign bus.id_jal        = dec_p1.jal;
    assign bus.id_jalr       = dec_p1.jalr;
    assign bus.id_branch     = dec_p1.branch;
    assign bus.id_mem_write  = dec_p1.mem_write;
    assign bus.id_mem_to_reg = dec_p1.mem_to_reg;
    assign bus.id_illegal    = dec_p1.illegal;
endmodule
